// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, consecutive-sample debounce,
// press/release pulses and long-press detection with optional auto-repeat.

module key_debounce_multi_ch #(
  parameter int DEBOUNCE_CYCLES = 24,
  parameter int LONG_CYCLES     = 120,
  parameter int REPEAT_CYCLES   = 48,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);
  localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic IDLE = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

  logic          s1_q, s1_d, s2_q, s2_d, st_q, st_d, lp_q, lp_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d, rel_q, rel_d, long_q, long_d, rep_q, rep_d;

  always_comb begin
    s1_d   = key_i ^ IDLE;
    s2_d   = s1_q;
    st_d   = st_q;
    dcnt_d = '0;
    if (s2_q != st_q) begin
      if (dcnt_q == D_LAST) st_d = s2_q;
      else                  dcnt_d = dcnt_q + 1'b1;
    end
    press_d = st_d & ~st_q;
    rel_d   = ~st_d & st_q;

    hcnt_d = hcnt_q;
    lp_d   = lp_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    // Idle, press edge or release edge: timer restarts and nothing fires.
    if (!st_d || !st_q) begin
      hcnt_d = '0;
      lp_d   = 1'b0;
    end else if (LONG_CYCLES > 0) begin
      if (!lp_q) begin
        if (hcnt_q == L_LAST) begin
          long_d = 1'b1;
          lp_d   = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end else if (REPEAT_CYCLES > 0) begin
        if (hcnt_q == R_LAST) begin
          rep_d  = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= IDLE;
      s2_q    <= IDLE;
      st_q    <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      lp_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      st_q    <= st_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      lp_q    <= lp_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
    end
  end

  assign level_o   = st_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;
endmodule

module key_debounce_multi #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 24,
  parameter int LONG_CYCLES     = 120,
  parameter int REPEAT_CYCLES   = 48,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] key_level,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_pulse,
  output logic [N-1:0] repeat_pulse
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    key_debounce_multi_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_i    (key[i]),
      .level_o  (key_level[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i]),
      .long_o   (long_pulse[i]),
      .repeat_o (repeat_pulse[i])
    );
  end
endmodule
